// File: rtl/io_bus_arbiter.sv
// Two-port arbiter for the 8-bit local I/O bus: round-robin with a bounded lock,
// one access at a time, registered bus drive and a one-cycle completion ack per grant.
module io_bus_arbiter #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned MAX_LOCK      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    output logic              io_we,
    input  logic [DATA_W-1:0] io_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int unsigned RUN_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant;
    logic               r_lock_valid;
    logic [RUN_W-1:0]   r_lock_run;

    logic               w_win;
    logic               w_req_owner;
    logic               w_req_other;
    logic               w_lock_owner;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_we;

    assign w_req_owner  = owner ? req1  : req0;
    assign w_req_other  = owner ? req0  : req1;
    assign w_lock_owner = owner ? lock1 : lock0;

    // Lock holder keeps the bus while it still requests; otherwise round-robin on a tie.
    always_comb begin
        w_win = 1'b0;
        if (r_lock_valid && w_req_owner) begin
            w_win = owner;
        end else if (req0 && req1) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = req1;
        end
    end

    assign w_addr  = w_win ? addr1  : addr0;
    assign w_wdata = w_win ? wdata1 : wdata0;
    assign w_we    = w_win ? we1    : we0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_lock_valid <= 1'b0;
            r_lock_run   <= '0;
            io_addr      <= '0;
            io_wdata     <= '0;
            io_we        <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            busy         <= 1'b0;
            owner        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        io_addr  <= w_addr;
                        io_wdata <= w_wdata;
                        io_we    <= w_we;
                        owner    <= w_win;
                        r_cnt    <= CNT_INIT;
                        busy     <= 1'b1;
                        r_state  <= S_ACCESS;
                        // A lock only survives while the same port keeps winning.
                        if (w_win != owner) begin
                            r_lock_valid <= 1'b0;
                            r_lock_run   <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        if (io_we) begin
                            if (owner) rdata1 <= io_rdata;
                            else       rdata0 <= io_rdata;
                        end
                        if (owner) ack1 <= 1'b1;
                        else       ack0 <= 1'b1;
                        io_we   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack0         <= 1'b0;
                    ack1         <= 1'b0;
                    busy         <= 1'b0;
                    r_last_grant <= owner;
                    r_state      <= S_IDLE;
                    // Run count saturates so a waiting peer forces a yield one grant later.
                    if (w_lock_owner) begin
                        if (w_req_other && (r_lock_run == RUN_LIMIT)) begin
                            r_lock_valid <= 1'b0;
                            r_lock_run   <= '0;
                        end else begin
                            r_lock_valid <= 1'b1;
                            if (r_lock_run != RUN_LIMIT) begin
                                r_lock_run <= r_lock_run + RUN_W'(1);
                            end
                        end
                    end else begin
                        r_lock_valid <= 1'b0;
                        r_lock_run   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: directed accesses push expected acks,
// a negedge monitor pops and compares port, cycle, read data and write-strobe count.
module tb_io_bus_arbiter;

    typedef struct {
        bit         port;
        logic [7:0] rd;
        int         cyc;
        int         we_low;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 1, we1 = 1;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic       ack0, ack1, io_we, busy, owner;
    logic [7:0] rdata0, rdata1, io_addr, io_wdata, io_rdata;

    logic       t_req = 0;
    logic [7:0] t_addr = 0;
    logic       zero1 = 1'b0;
    logic       one1 = 1'b1;
    logic [7:0] zero8 = 8'h00;
    logic       ack0_3, ack1_3, io_we3, busy3, owner3;
    logic [7:0] rdata0_3, rdata1_3, io_addr3, io_wdata3, io_rdata3;

    logic [7:0] mem [256];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         we_low = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign io_rdata  = mem[io_addr];
    assign io_rdata3 = 8'(cyc) + 8'h40;

    always @(posedge clk) begin
        if (rst_n && !io_we) mem[io_addr] <= io_wdata;
    end

    io_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(1), .MAX_LOCK(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_rdata(io_rdata),
        .busy(busy), .owner(owner)
    );

    io_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(3), .MAX_LOCK(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0(t_req), .req1(zero1), .lock0(zero1), .lock1(zero1),
        .we0(one1), .we1(one1), .addr0(t_addr), .addr1(zero8),
        .wdata0(zero8), .wdata1(zero8),
        .ack0(ack0_3), .ack1(ack1_3), .rdata0(rdata0_3), .rdata1(rdata1_3),
        .io_addr(io_addr3), .io_wdata(io_wdata3), .io_we(io_we3), .io_rdata(io_rdata3),
        .busy(busy3), .owner(owner3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit port, input logic [7:0] rd, input int c, input int wl);
        exp_t e;
        e.port = port; e.rd = rd; e.cyc = c; e.we_low = wl;
        sb.push_back(e);
    endtask

    // Monitor: every ack is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (!rst_n) begin
            we_low = 0;
        end else begin
            if (!io_we) we_low++;
            if (ack0 && ack1) chk("dual_ack", 32'(1), 32'(0));
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack1), 32'(2));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_port",  32'(ack1), 32'(e.port));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ack_rdata", 32'(ack1 ? rdata1 : rdata0), 32'(e.rd));
                    chk("we_low_cycles", 32'(we_low), 32'(e.we_low));
                end
                we_low = 0;
            end
        end
    end

    // Single access on one port; request dropped once the DONE edge has passed.
    task automatic single(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        @(posedge clk); #1;
        if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
        else      begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
        push(port, exp_rd, cyc + 2, we ? 0 : 1);
        repeat (3) @(posedge clk);
        #1;
        if (port) req1 = 0; else req0 = 0;
    endtask

    initial begin
        int c;
        logic [7:0] e3;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_io_we",   32'(io_we),   32'(1));
        chk("rst_io_addr", 32'(io_addr), 32'(0));
        chk("rst_busy",    32'(busy),    32'(0));
        chk("rst_owner",   32'(owner),   32'(0));
        chk("rst_rdata0",  32'(rdata0),  32'(0));
        chk("rst_ack",     32'({ack0, ack1}), 32'(0));

        single(1'b0, 1'b1, 8'h00, 8'h00, 8'hA5);

        // Port 1 write: strobe exactly one cycle with the latched address/data.
        @(posedge clk); #1;
        req1 = 1; we1 = 0; addr1 = 8'h10; wdata1 = 8'h3C;
        push(1'b1, 8'h00, cyc + 2, 1);
        @(posedge clk);
        @(negedge clk);
        chk("wr_io_we",    32'(io_we),    32'(0));
        chk("wr_io_addr",  32'(io_addr),  32'(8'h10));
        chk("wr_io_wdata", 32'(io_wdata), 32'(8'h3C));
        chk("wr_busy",     32'(busy),     32'(1));
        chk("wr_owner",    32'(owner),    32'(1));
        @(negedge clk);
        chk("wr_io_we_ack", 32'(io_we), 32'(1));
        @(posedge clk); #1;
        req1 = 0; we1 = 1;

        single(1'b1, 1'b1, 8'h10, 8'h00, 8'h3C);

        // Contention without lock alternates 0,1,0,1 with a 3-cycle period.
        @(posedge clk); #1;
        addr0 = 8'h00; we0 = 1; addr1 = 8'h10; we1 = 1;
        req0 = 1; req1 = 1;
        c = cyc;
        for (int k = 0; k < 4; k++) push(k[0], k[0] ? 8'h3C : 8'hA5, c + 2 + 3 * k, 0);
        repeat (12) @(posedge clk);
        #1 req0 = 0; req1 = 0;

        // Port 0 locked: four port-0 grants, then a forced yield to port 1.
        @(posedge clk); #1;
        lock0 = 1; req0 = 1; req1 = 1;
        c = cyc;
        for (int k = 0; k < 5; k++) push(k == 4, (k == 4) ? 8'h3C : 8'hA5, c + 2 + 3 * k, 0);
        repeat (15) @(posedge clk);
        #1 req0 = 0; req1 = 0; lock0 = 0;

        // Reset asserted during a write access: strobe drops at once, no ack.
        repeat (2) @(posedge clk);
        #1 req0 = 1; we0 = 0; addr0 = 8'h20; wdata0 = 8'h77;
        @(posedge clk); #1;
        chk("rstw_io_we_low", 32'(io_we), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_io_we_async", 32'(io_we), 32'(1));
        chk("rstw_busy_async",  32'(busy),  32'(0));
        repeat (2) @(posedge clk);
        #1 req0 = 0; we0 = 1; rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_busy",   32'(busy),   32'(0));
        chk("rstw_io_we",  32'(io_we),  32'(1));
        chk("rstw_rdata0", 32'(rdata0), 32'(0));
        chk("rstw_mem",    32'(mem[8'h20]), 32'(0));
        repeat (3) @(negedge clk);
        chk("rstw_no_ack", 32'({ack0, ack1}), 32'(0));

        // Three-cycle access: address held, no strobe, data of the third cycle captured.
        @(posedge clk); #1;
        t_req = 1; t_addr = 8'h42;
        c = cyc;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ac3_io_we",   32'(io_we3),   32'(1));
            chk("ac3_io_addr", 32'(io_addr3), 32'(8'h42));
            chk("ac3_no_ack",  32'(ack0_3),   32'(0));
        end
        @(negedge clk);
        e3 = 8'(c + 3) + 8'h40;
        chk("ac3_ack",   32'(ack0_3),   32'(1));
        chk("ac3_cycle", 32'(cyc),      32'(c + 4));
        chk("ac3_rdata", 32'(rdata0_3), 32'(e3));
        @(posedge clk); #1;
        t_req = 0;

        repeat (6) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
